cg_vector_pingpong_mem: RTL

- Responder-side vector store for the CG datapath. Holds one CG vector (r, x or p) as rows of NO_OF_UNITS packed elements.
- Serves the ALU's pulse-per-row read protocol (read strobe, read restart) from the "old" bank. Accepts the ALU's write-enable/data stream into the "new" bank.
- Swaps banks at iteration end, so the next iteration reads what the last one wrote.
- One instance per vector, between the ALU and its memories.

---
 rtl/cg_vector_pingpong_mem_pkg.sv | 18 +
 rtl/cg_vector_pingpong_mem_row_ram.sv | 37 +++
 rtl/cg_vector_pingpong_mem.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cg_vector_pingpong_mem_pkg.sv
// cg_pkg: shared constants and types for the CG vector ping-pong store.
//   CG_* sizing constants, row_t (one packed row of elements), the error
//   bit positions of the sticky err vector, and the store's state type.
package cg_pkg;
   localparam int CG_ELEMENT_WIDTH = 32;
   localparam int CG_NO_OF_UNITS   = 8;
   localparam int CG_MEMORY_HEIGHT = 1000;
   localparam int CG_ROW_WIDTH     = CG_ELEMENT_WIDTH * CG_NO_OF_UNITS;
   localparam int CG_ADDR_WIDTH    = $clog2(CG_MEMORY_HEIGHT) + 1;

   typedef logic [CG_ROW_WIDTH-1:0] row_t;

   localparam int ERR_RD_OVERRUN      = 0;
   localparam int ERR_WR_OVERRUN      = 1;
   localparam int ERR_SWAP_INCOMPLETE = 2;

   typedef enum logic {ST_LOAD, ST_RUN} state_t;
endpackage

// File: rtl/cg_vector_pingpong_mem_row_ram.sv
// cg_row_ram: one bank of row storage, one write port and two synchronous
// read ports.
//   clk            clock
//   clr            clears both read registers (contents untouched)
//   we/waddr/wdata write port
//   re_a/addr_a    sequential read port, q_a holds between enables
//   addr_b         random-access read port, read every cycle
//   q_a/q_b        registered read data, 1-cycle latency, read-before-write
module cg_row_ram #(
   parameter int W     = 256,
   parameter int DEPTH = 1000,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re_a,
   input  logic [AW-1:0] addr_a,
   output logic [W-1:0]  q_a,
   input  logic [AW-1:0] addr_b,
   output logic [W-1:0]  q_b
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   always_ff @(posedge clk)
      if (clr)       q_a <= '0;
      else if (re_a) q_a <= mem[addr_a];

   always_ff @(posedge clk)
      if (clr) q_b <= '0;
      else     q_b <= mem[addr_b];
endmodule

// File: rtl/cg_vector_pingpong_mem.sv
// cg_vector_pingpong_mem: two-bank store for one CG vector.
//   Reads (strobed and random) come from the old bank (bank_sel), writes
//   go to the other bank; swap flips the roles at iteration end.
//   clk, reset        clock, synchronous active-high reset
//   total             vector length in elements (rows = total/NO_OF_UNITS)
//   load_we/load_data initial vector rows, LOAD state only
//   rd_strobe/rd_restart/rd_data/rd_valid/rd_done  row-per-pulse read
//   rand_addr/rand_data                            random row read
//   wr_we/wr_data/wr_count/wr_done                 result row stream
//   swap/bank_sel/running/err                      control and status
module cg_vector_pingpong_mem
   import cg_pkg::*;
#(
   parameter int ELEMENT_WIDTH = CG_ELEMENT_WIDTH,
   parameter int NO_OF_UNITS   = CG_NO_OF_UNITS,
   parameter int MEMORY_HEIGHT = CG_MEMORY_HEIGHT,
   parameter int ADDR_WIDTH    = $clog2(MEMORY_HEIGHT) + 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [31:0]                         total,
   input  logic                                load_we,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] load_data,
   input  logic                                rd_strobe,
   input  logic                                rd_restart,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data,
   output logic                                rd_valid,
   output logic                                rd_done,
   input  logic [31:0]                         rand_addr,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rand_data,
   input  logic                                wr_we,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
   output logic [31:0]                         wr_count,
   output logic                                wr_done,
   input  logic                                swap,
   output logic                                bank_sel,
   output logic                                running,
   output logic [2:0]                          err
);
   localparam int RW  = ELEMENT_WIDTH * NO_OF_UNITS;
   localparam int RAW = $clog2(MEMORY_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] MAX_ROWS = ADDR_WIDTH'(MEMORY_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

   state_t state, state_nx;
   logic [ADDR_WIDTH-1:0] rows, load_ptr, rd_ptr, wr_ptr, rd_eff;
   logic [31:0] rows_raw;
   logic load_fire, rd_fire, rd_ovr, wr_fire, wr_ovr, swap_fire, swap_short;
   logic sel_q, rand_oob, rand_oob_q;
   logic we0, we1;
   logic [RW-1:0] q0a, q1a, q0b, q1b;

   assign rows_raw = total / 32'(NO_OF_UNITS);
   assign rows     = (rows_raw > 32'(MEMORY_HEIGHT)) ? MAX_ROWS : rows_raw[ADDR_WIDTH-1:0];
   assign rand_oob = rand_addr >= 32'(rows);

   always_ff @(posedge clk)
      if (reset) state <= ST_LOAD;
      else       state <= state_nx;

   // Event qualification; a swap drops a same-cycle strobe but not a write.
   always_comb begin
      state_nx  = state;
      load_fire = 1'b0;
      rd_fire   = 1'b0;
      rd_ovr    = 1'b0;
      wr_fire   = 1'b0;
      wr_ovr    = 1'b0;
      swap_fire = 1'b0;
      rd_eff    = rd_restart ? '0 : rd_ptr;
      if (!reset) begin
         case (state)
            ST_LOAD: begin
               load_fire = load_we && (load_ptr < rows);
               if (load_ptr == rows) state_nx = ST_RUN;
            end
            ST_RUN: begin
               swap_fire = swap;
               wr_fire   = wr_we && (wr_ptr < rows);
               wr_ovr    = wr_we && !(wr_ptr < rows);
               rd_fire   = rd_strobe && !swap && (rd_eff < rows);
               rd_ovr    = rd_strobe && !swap && !(rd_eff < rows);
            end
            default: state_nx = ST_LOAD;
         endcase
      end
   end

   // Completeness at swap counts a write landing in the swap cycle.
   assign swap_short = (wr_ptr + (wr_fire ? ONE : '0)) != rows;

   always_ff @(posedge clk) begin
      if (reset) begin
         load_ptr   <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         bank_sel   <= 1'b0;
         sel_q      <= 1'b0;
         rd_valid   <= 1'b0;
         rand_oob_q <= 1'b0;
         err        <= '0;
      end else begin
         sel_q      <= bank_sel;
         rand_oob_q <= rand_oob;
         rd_valid   <= rd_fire;
         if (load_fire) load_ptr <= load_ptr + ONE;
         if (swap_fire) begin
            bank_sel <= ~bank_sel;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else if (state == ST_RUN) begin
            rd_ptr <= rd_fire ? rd_eff + ONE : rd_eff;
            if (wr_fire) wr_ptr <= wr_ptr + ONE;
         end
         if (rd_ovr)                   err[ERR_RD_OVERRUN]      <= 1'b1;
         if (wr_ovr)                   err[ERR_WR_OVERRUN]      <= 1'b1;
         if (swap_fire && swap_short)  err[ERR_SWAP_INCOMPLETE] <= 1'b1;
      end
   end

   // Load fills the old bank, the result stream fills the new bank; the two
   // never fire together so they share one address/data path.
   assign we0 = (load_fire && !bank_sel) || (wr_fire && bank_sel);
   assign we1 = (load_fire && bank_sel)  || (wr_fire && !bank_sel);

   cg_row_ram #(.W(RW), .DEPTH(MEMORY_HEIGHT), .AW(RAW)) u_bank0 (
      .clk(clk), .clr(reset), .we(we0),
      .waddr(load_fire ? load_ptr[RAW-1:0] : wr_ptr[RAW-1:0]),
      .wdata(load_fire ? load_data : wr_data),
      .re_a(rd_fire && !bank_sel), .addr_a(rd_eff[RAW-1:0]), .q_a(q0a),
      .addr_b(rand_addr[RAW-1:0]), .q_b(q0b)
   );

   cg_row_ram #(.W(RW), .DEPTH(MEMORY_HEIGHT), .AW(RAW)) u_bank1 (
      .clk(clk), .clr(reset), .we(we1),
      .waddr(load_fire ? load_ptr[RAW-1:0] : wr_ptr[RAW-1:0]),
      .wdata(load_fire ? load_data : wr_data),
      .re_a(rd_fire && bank_sel), .addr_a(rd_eff[RAW-1:0]), .q_a(q1a),
      .addr_b(rand_addr[RAW-1:0]), .q_b(q1b)
   );

   // Output mux follows the bank that was old when the read was issued.
   assign rd_data   = sel_q ? q1a : q0a;
   assign rand_data = rand_oob_q ? '0 : (sel_q ? q1b : q0b);
   assign rd_done   = rd_ptr == rows;
   assign wr_done   = wr_ptr == rows;
   assign wr_count  = 32'(wr_ptr);
   assign running   = state == ST_RUN;
endmodule
